// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - Decode/Execute hazard bus between pipeline and hazard_controller
interface hazard_controller_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic                      id_valid;
  logic                      id_reg_write;
  logic                      id_branch;
  logic                      id_jump;
  logic [1:0]                id_result_src;
  logic                      ex_zero;
  logic                      mem_busy;

  logic                      stall_f;
  logic                      stall_d;
  logic                      flush_d;
  logic                      flush_e;
  logic                      freeze;
  logic                      pc_src;
  logic [1:0]                fwd_a_e;
  logic [1:0]                fwd_b_e;
  logic [CNT_WIDTH-1:0]      stall_count;
  logic [CNT_WIDTH-1:0]      flush_count;

  // Pipeline side: drives Decode/Execute status, consumes hazard controls.
  modport master (
    output id_rs1, id_rs2, id_rd, id_valid, id_reg_write, id_branch, id_jump,
           id_result_src, ex_zero, mem_busy,
    input  stall_f, stall_d, flush_d, flush_e, freeze, pc_src,
           fwd_a_e, fwd_b_e, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_rd, id_valid, id_reg_write, id_branch, id_jump,
           id_result_src, ex_zero, mem_busy,
    output stall_f, stall_d, flush_d, flush_e, freeze, pc_src,
           fwd_a_e, fwd_b_e, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - 5-stage pipeline hazard unit: load-use stall, redirect flush, forwarding, event counters
module hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_controller_if.slave hz
);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Execute-stage shadow
  logic                      e_valid_q, e_reg_write_q, e_is_load_q, e_branch_q, e_jump_q;
  logic [REG_ADDR_WIDTH-1:0] e_rs1_q, e_rs2_q, e_rd_q;
  // Memory- and Writeback-stage shadows
  logic                      m_valid_q, m_reg_write_q;
  logic [REG_ADDR_WIDTH-1:0] m_rd_q;
  logic                      w_valid_q, w_reg_write_q;
  logic [REG_ADDR_WIDTH-1:0] w_rd_q;

  logic [CNT_WIDTH-1:0]      stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0]      flush_count_q, flush_count_d;

  logic busy;
  logic lw_stall;
  logic redirect;
  logic flush_e_c;
  logic m_fwd_ok, w_fwd_ok;

  // Outputs must read idle while reset is held, even if memory reports busy.
  assign busy = hz.mem_busy & rst_n;

  always_comb begin
    lw_stall = hz.id_valid & e_valid_q & e_is_load_q & (e_rd_q != REG_ZERO) &
               ((e_rd_q == hz.id_rs1) | (e_rd_q == hz.id_rs2));
    redirect = e_valid_q & (e_jump_q | (e_branch_q & hz.ex_zero));
  end

  always_comb begin
    hz.stall_f = 1'b0;
    hz.stall_d = 1'b0;
    hz.flush_d = 1'b0;
    hz.flush_e = 1'b0;
    hz.freeze  = 1'b0;
    hz.pc_src  = 1'b0;
    flush_e_c  = 1'b0;
    if (busy) begin
      hz.freeze  = 1'b1;
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
    end else begin
      flush_e_c  = redirect | lw_stall;
      hz.pc_src  = redirect;
      hz.flush_d = redirect;
      hz.flush_e = flush_e_c;
      hz.stall_f = lw_stall & ~redirect;
      hz.stall_d = lw_stall & ~redirect;
    end
  end

  // A bubble in Execute has no consumer, so it never selects a bypass.
  always_comb begin
    m_fwd_ok   = e_valid_q & m_valid_q & m_reg_write_q & (m_rd_q != REG_ZERO);
    w_fwd_ok   = e_valid_q & w_valid_q & w_reg_write_q & (w_rd_q != REG_ZERO);
    hz.fwd_a_e = 2'b00;
    hz.fwd_b_e = 2'b00;
    if (m_fwd_ok && (m_rd_q == e_rs1_q)) begin
      hz.fwd_a_e = 2'b10;
    end else if (w_fwd_ok && (w_rd_q == e_rs1_q)) begin
      hz.fwd_a_e = 2'b01;
    end
    if (m_fwd_ok && (m_rd_q == e_rs2_q)) begin
      hz.fwd_b_e = 2'b10;
    end else if (w_fwd_ok && (w_rd_q == e_rs2_q)) begin
      hz.fwd_b_e = 2'b01;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!busy) begin
      if (lw_stall && !redirect && !(&stall_count_q)) begin
        stall_count_d = stall_count_q + CNT_ONE;
      end
      if (redirect && !(&flush_count_q)) begin
        flush_count_d = flush_count_q + CNT_ONE;
      end
    end
  end

  assign hz.stall_count = stall_count_q;
  assign hz.flush_count = flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_q     <= 1'b0;
      e_reg_write_q <= 1'b0;
      e_is_load_q   <= 1'b0;
      e_branch_q    <= 1'b0;
      e_jump_q      <= 1'b0;
      e_rs1_q       <= '0;
      e_rs2_q       <= '0;
      e_rd_q        <= '0;
      m_valid_q     <= 1'b0;
      m_reg_write_q <= 1'b0;
      m_rd_q        <= '0;
      w_valid_q     <= 1'b0;
      w_reg_write_q <= 1'b0;
      w_rd_q        <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else if (!busy) begin
      e_valid_q     <= hz.id_valid & ~flush_e_c;
      e_reg_write_q <= hz.id_reg_write;
      e_is_load_q   <= (hz.id_result_src == 2'b01);
      e_branch_q    <= hz.id_branch;
      e_jump_q      <= hz.id_jump;
      e_rs1_q       <= hz.id_rs1;
      e_rs2_q       <= hz.id_rs2;
      e_rd_q        <= hz.id_rd;
      m_valid_q     <= e_valid_q;
      m_reg_write_q <= e_reg_write_q;
      m_rd_q        <= e_rd_q;
      w_valid_q     <= m_valid_q;
      w_reg_write_q <= m_reg_write_q;
      w_rd_q        <= m_rd_q;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end
endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - vector table and scoreboard bench for hazard_controller
module tb_hazard_controller;
  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw;
    logic [1:0] src;
    logic       br, jmp, zero, busy;
    logic [5:0] ctl;
    logic [1:0] fa, fb;
    logic [3:0] sc, fc;
  } vec_t;

  // ctl = {stall_f, stall_d, flush_d, flush_e, freeze, pc_src}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b110100;
  localparam logic [5:0] C_REDIR = 6'b001101;
  localparam logic [5:0] C_BUSY  = 6'b110010;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  vec_t tbl[$];
  vec_t sb[$];

  hazard_controller_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) hif ();

  hazard_controller #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic rw, input logic [1:0] src,
                              input logic br, input logic jmp, input logic zero, input logic busy,
                              input logic [5:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [3:0] sc, input logic [3:0] fc);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.rw = rw; r.src = src;
    r.br = br; r.jmp = jmp; r.zero = zero; r.busy = busy;
    r.ctl = ctl; r.fa = fa; r.fb = fb; r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, got, want);
    end
  endtask

  task automatic check_out(input vec_t e, input int idx);
    chk("ctl", idx, {2'b00, hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e, hif.freeze, hif.pc_src},
        {2'b00, e.ctl});
    chk("fwd", idx, {4'h0, hif.fwd_a_e, hif.fwd_b_e}, {4'h0, e.fa, e.fb});
    chk("cnt", idx, {hif.stall_count, hif.flush_count}, {e.sc, e.fc});
  endtask

  task automatic drive(input vec_t e);
    hif.id_valid      = e.v;
    hif.id_rs1        = e.rs1;
    hif.id_rs2        = e.rs2;
    hif.id_rd         = e.rd;
    hif.id_reg_write  = e.rw;
    hif.id_result_src = e.src;
    hif.id_branch     = e.br;
    hif.id_jump       = e.jmp;
    hif.ex_zero       = e.zero;
    hif.mem_busy      = e.busy;
  endtask

  // One pipeline cycle: drive after the edge, queue the expectation, compare mid-cycle.
  task automatic step(input vec_t e, input int idx);
    vec_t got_e;
    @(posedge clk);
    #1;
    drive(e);
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty[%0d] got 0 entries want 1", idx);
    end else begin
      got_e = sb.pop_front();
      check_out(got_e, idx);
    end
  endtask

  initial begin
    vec_t nop, jal, e;
    logic [3:0] fc_exp;
    n_checks = 0;
    n_errors = 0;
    nop = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, C_NONE, 0, 0, 0, 0);

    //        v rs1 rs2 rd rw src   br jmp z bsy ctl      fa fb sc fc
    tbl.push_back(mk(1, 1, 0, 5, 1, 2'b01, 0, 0, 0, 0, C_NONE,  0, 0, 0, 0)); // lw x5
    tbl.push_back(mk(1, 5, 2, 6, 1, 2'b00, 0, 0, 0, 0, C_STALL, 0, 0, 0, 0)); // add uses x5
    tbl.push_back(mk(1, 5, 2, 6, 1, 2'b00, 0, 0, 0, 0, C_NONE,  0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, C_NONE,  1, 0, 1, 0)); // load now in W
    tbl.push_back(mk(1, 1, 2, 3, 1, 2'b00, 0, 0, 0, 0, C_NONE,  0, 0, 1, 0)); // add x3 (older)
    tbl.push_back(mk(1, 1, 2, 3, 1, 2'b00, 0, 0, 0, 0, C_NONE,  0, 0, 1, 0)); // add x3 (newer)
    tbl.push_back(mk(1, 4, 3, 7, 1, 2'b00, 0, 0, 0, 0, C_NONE,  0, 0, 1, 0)); // sub rs2=x3
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, C_NONE,  0, 2, 1, 0)); // M beats W
    tbl.push_back(mk(1, 1, 2, 0, 0, 2'b00, 1, 0, 0, 0, C_NONE,  0, 0, 1, 0)); // beq
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, C_REDIR, 0, 0, 1, 0)); // taken
    tbl.push_back(mk(1, 1, 2, 0, 0, 2'b00, 1, 0, 0, 0, C_NONE,  0, 0, 1, 1)); // beq
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, C_NONE,  0, 0, 1, 1)); // not taken
    tbl.push_back(mk(1, 1, 0, 0, 1, 2'b01, 0, 0, 0, 0, C_NONE,  0, 0, 1, 1)); // lw x0
    tbl.push_back(mk(1, 0, 0, 8, 1, 2'b00, 0, 0, 0, 0, C_NONE,  0, 0, 1, 1)); // reads x0: no stall
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, C_NONE,  0, 0, 1, 1)); // x0 in M: no fwd
    tbl.push_back(mk(1, 0, 0, 9, 1, 2'b01, 0, 1, 0, 0, C_NONE,  0, 0, 1, 1)); // jump tagged as load
    tbl.push_back(mk(1, 9, 0, 10, 1, 2'b00, 0, 0, 0, 0, C_REDIR, 0, 0, 1, 1)); // redirect wins
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, C_NONE,  0, 0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 1, 1, 2'b00, 0, 1, 0, 0, C_NONE,  0, 0, 1, 2)); // jal
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, C_BUSY,  0, 0, 1, 2)); // frozen x3
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, C_BUSY,  0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, C_BUSY,  0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, C_REDIR, 0, 0, 1, 2)); // fires on release
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, C_NONE,  0, 0, 1, 3));
    tbl.push_back(mk(1, 0, 0, 4, 1, 2'b01, 0, 0, 0, 0, C_NONE,  0, 0, 1, 3)); // lw x4
    tbl.push_back(mk(1, 0, 4, 11, 1, 2'b00, 0, 0, 0, 1, C_BUSY, 0, 0, 1, 3)); // busy masks stall
    tbl.push_back(mk(1, 0, 4, 11, 1, 2'b00, 0, 0, 0, 0, C_STALL, 0, 0, 1, 3));
    tbl.push_back(mk(1, 0, 4, 11, 1, 2'b00, 0, 0, 0, 0, C_NONE, 0, 0, 2, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, C_NONE,  0, 1, 2, 3)); // rs2 from W

    // Reset with busy and a live Decode instruction: outputs must stay idle.
    rst_n = 1'b0;
    e = mk(1, 5, 5, 5, 1, 2'b01, 1, 1, 1, 1, C_NONE, 0, 0, 0, 0);
    drive(e);
    repeat (2) @(negedge clk);
    check_out(e, -1);
    drive(nop);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i], i);

    // Saturation: 18 redirects into a 4-bit counter.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fc_exp = 4'd0;
    jal = mk(1, 0, 0, 1, 1, 2'b00, 0, 1, 0, 0, C_NONE, 0, 0, 0, 0);
    for (int k = 0; k < 18; k++) begin
      e = jal;
      e.fc = fc_exp;
      step(e, 100 + 2 * k);
      e = nop;
      e.ctl = C_REDIR;
      e.fc = fc_exp;
      step(e, 101 + 2 * k);
      fc_exp = (fc_exp == 4'hf) ? 4'hf : fc_exp + 4'd1;
    end
    e = jal;
    e.fc = fc_exp;
    step(e, 200);

    // Asynchronous reset in the middle of a redirect cycle.
    @(posedge clk);
    #1;
    drive(nop);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_cnt", 201, {hif.stall_count, hif.flush_count}, 8'h00);
    chk("async_ctl", 201, {2'b00, hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e, hif.freeze, hif.pc_src},
        8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(nop, 202);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
